// File: rtl/i2c_cfg_pkg.sv
// Shared types for the I2C configuration sequencer: table entry layout, entry types,
// FSM state encoding and the NACK retry limit.
package i2c_cfg_pkg;

  localparam int unsigned EntryW         = 37;
  localparam int unsigned RetryLimit     = 3;
  localparam int unsigned WaitBusyCycles = 4;

  typedef enum logic [1:0] {
    EntWrite = 2'd0,
    EntDelay = 2'd1,
    EntEnd   = 2'd2
  } entry_type_e;

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StLaunch,
    StWaitBusy,
    StWaitDone,
    StCheck,
    StDelay,
    StFinish,
    StFault
  } state_e;

  typedef struct packed {
    logic [1:0]  typ;
    logic [2:0]  nbytes;
    logic [15:0] ptr;
    logic [15:0] dat;
  } entry_t;

  localparam logic [EntryW-1:0] EndEntry = {EntEnd, 35'd0};

  function automatic logic [EntryW-1:0] make_entry(logic [1:0] typ, logic [2:0] nbytes,
                                                   logic [15:0] ptr, logic [15:0] dat);
    return {typ, nbytes, ptr, dat};
  endfunction

endpackage

// File: rtl/i2c_config_rom.sv
// Configuration table with a registered read port; entries beyond Depth read as END.
module i2c_config_rom
  import i2c_cfg_pkg::*;
#(
  parameter int unsigned              Depth = 16,
  parameter logic [Depth*EntryW-1:0]  Table = {Depth{EndEntry}}
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        addr_i,
  output logic [EntryW-1:0] data_o
);

  logic [EntryW-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= EndEntry;
    end else if (32'(addr_i) < Depth) begin
      data_q <= Table[32'(addr_i)*EntryW +: EntryW];
    end else begin
      data_q <= EndEntry;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks a table of WRITE / DELAY / END entries and drives an external I2C writer.
// Optional NACK retry is enabled with the I2C_CFG_RETRY_EN macro.
module i2c_config_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter logic [7:0]                    SLAVE_ADDR  = 8'h88,
  parameter int unsigned                   TABLE_DEPTH = 16,
  parameter int unsigned                   DELAY_UNIT  = 1000,
  parameter int unsigned                   TIMEOUT     = 65535,
  parameter logic [TABLE_DEPTH*EntryW-1:0] TABLE       = {TABLE_DEPTH{EndEntry}}
) (
  input  logic        PT_CK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic        END_OK,
  input  logic        ACK_OK,
  output logic        GO,
  output logic [7:0]  SLAVE_ADDRESS,
  output logic [15:0] POINTER,
  output logic [15:0] WDATA,
  output logic [7:0]  BYTE_NUM,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [7:0]  INDEX
);

  state_e      state_q, state_d;
  logic [7:0]  index_q, index_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  bytenum_q, bytenum_d;
  logic [7:0]  slave_q;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        ack_q, ack_d;
  logic [31:0] cnt_q, cnt_d;
`ifdef I2C_CFG_RETRY_EN
  logic [1:0]  retry_q, retry_d;
`endif

  logic [EntryW-1:0] rom_data;
  entry_t            entry;

  // Addressed with the next index so the entry is already valid on entry to LOAD.
  i2c_config_rom #(
    .Depth (TABLE_DEPTH),
    .Table (TABLE)
  ) u_rom (
    .clk_i  (PT_CK),
    .rst_ni (RESET_N),
    .addr_i (index_d),
    .data_o (rom_data)
  );

  assign entry = rom_data;

  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      index_q   <= '0;
      ptr_q     <= '0;
      wdata_q   <= '0;
      bytenum_q <= '0;
      slave_q   <= SLAVE_ADDR;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      ack_q     <= 1'b0;
      cnt_q     <= '0;
`ifdef I2C_CFG_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      ptr_q     <= ptr_d;
      wdata_q   <= wdata_d;
      bytenum_q <= bytenum_d;
      slave_q   <= slave_q;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      ack_q     <= ack_d;
      cnt_q     <= cnt_d;
`ifdef I2C_CFG_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    ptr_d     = ptr_q;
    wdata_d   = wdata_q;
    bytenum_d = bytenum_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    ack_d     = ack_q;
    cnt_d     = cnt_q;
`ifdef I2C_CFG_RETRY_EN
    retry_d   = retry_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (START) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          index_d = '0;
          busy_d  = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
`ifdef I2C_CFG_RETRY_EN
        retry_d = '0;
`endif
        if (32'(index_q) >= TABLE_DEPTH) begin
          state_d = StFinish;
        end else begin
          case (entry.typ)
            EntWrite: begin
              ptr_d     = entry.ptr;
              wdata_d   = entry.dat;
              bytenum_d = {5'b0, entry.nbytes};
              state_d   = StLaunch;
            end
            EntDelay: begin
              cnt_d   = 32'(entry.dat) * 32'(DELAY_UNIT);
              state_d = StDelay;
            end
            default: state_d = StFinish;
          endcase
        end
      end
      StLaunch: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (!END_OK) begin
          cnt_d   = '0;
          state_d = StWaitDone;
        end else if (cnt_q >= 32'(WaitBusyCycles - 1)) begin
          state_d = StFault;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StWaitDone: begin
        if (END_OK) begin
          state_d = StCheck;
        end else begin
          ack_d = ACK_OK;
          if (cnt_q >= 32'(TIMEOUT) - 32'd1) begin
            state_d = StFault;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      StCheck: begin
        if (ack_q) begin
          index_d = index_q + 8'd1;
          state_d = StLoad;
        end else begin
`ifdef I2C_CFG_RETRY_EN
          if (retry_q < 2'(RetryLimit)) begin
            retry_d = retry_q + 2'd1;
            state_d = StLaunch;
          end else begin
            state_d = StFault;
          end
`else
          state_d = StFault;
`endif
        end
      end
      StDelay: begin
        if (cnt_q == '0) begin
          index_d = index_q + 8'd1;
          state_d = StLoad;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      StFault: begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // GO low while the writer is parked starts a transfer, so only LAUNCH releases it.
  always_comb begin
    GO            = (state_q != StLaunch);
    SLAVE_ADDRESS = slave_q;
    POINTER       = ptr_q;
    WDATA         = wdata_q;
    BYTE_NUM      = bytenum_q;
    BUSY          = busy_q;
    DONE          = done_q;
    ERROR         = error_q;
    INDEX         = index_q;
  end

endmodule

// File: doc/i2c_config_sequencer.md
I2C_CONFIG_SEQUENCER -- requirements
Module: i2c_config_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- SLAVE_ADDR, 8'h88, 8-bit write address passed to the writer.
- TABLE_DEPTH, 16, number of table entries.
- DELAY_UNIT, 1000, PT_CK cycles per delay tick.
- TIMEOUT, 65535, maximum cycles to wait for the writer to finish.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- PT_CK, in, 1, clock.
- RESET_N, in, 1, reset: asynchronous, active-low.
- START, in, 1, one-cycle pulse that runs the table.
- END_OK, in, 1, writer idle flag.
- ACK_OK, in, 1, writer byte-ACK flag.
- GO, out, 1, writer launch control.
- SLAVE_ADDRESS, out, 8, to the writer.
- POINTER, out, 16, to the writer.
- WDATA, out, 16, to the writer.
- BYTE_NUM, out, 8, to the writer.
- BUSY, out, 1, sequence running.
- DONE, out, 1, sequence completed.
- ERROR, out, 1, sequence aborted.
- INDEX, out, 8, current entry.

Function
REQ-003 Each table entry SHALL be 37 bits: TYPE[1:0] (0 WRITE, 1 DELAY, 2 END), NBYTES[2:0], PTR[15:0], DAT[15:0].
REQ-004 The state machine SHALL have the states IDLE, LOAD, LAUNCH, WAIT_BUSY, WAIT_DONE, CHECK, DELAY, FINISH and FAULT.
REQ-005 Parking rule: GO SHALL be 1 in every state except LAUNCH, because the writer starts a new transfer whenever GO is low while it is parked.
REQ-006 In IDLE, START=1 SHALL clear DONE and ERROR, set INDEX=0 and BUSY=1, and move to LOAD. START SHALL be ignored while BUSY=1.
REQ-007 LOAD SHALL read entry INDEX (1-cycle ROM latency) and branch on TYPE:
- WRITE: register POINTER=PTR, WDATA=DAT, BYTE_NUM={5'b0,NBYTES}, then go to LAUNCH.
- DELAY: load the counter with DAT*DELAY_UNIT, then go to DELAY.
- END: go to FINISH.
REQ-008 SLAVE_ADDRESS, POINTER, WDATA and BYTE_NUM SHALL stay stable from LAUNCH until WAIT_DONE exits.
REQ-009 LAUNCH SHALL drive GO=0 for exactly one cycle, then go to WAIT_BUSY.
REQ-010 WAIT_BUSY SHALL exit to WAIT_DONE when END_OK=0, or to FAULT if END_OK stays 1 for 4 cycles.
REQ-011 In WAIT_DONE the block SHALL register ACK_OK every cycle in which END_OK=0. It SHALL exit to CHECK on END_OK=1, or to FAULT after TIMEOUT cycles.
REQ-012 CHECK SHALL use the last registered ACK_OK: 1 means INDEX+1 and go to LOAD; 0 means go to FAULT (see REQ-019).
REQ-013 DELAY SHALL decrement the counter to 0, then set INDEX+1 and go to LOAD. DAT=0 SHALL give a 1-cycle pass-through.
REQ-014 If INDEX reaches TABLE_DEPTH without an END entry, the block SHALL treat it as END.
REQ-015 FINISH SHALL set DONE=1 and BUSY=0, then go to IDLE. FAULT SHALL set ERROR=1 and BUSY=0, then go to IDLE. DONE and ERROR SHALL hold until the next START.

Reset
REQ-016 Reset SHALL put the block in IDLE with GO=1, BUSY=0, DONE=0, ERROR=0 and INDEX=0.
REQ-017 Reset SHALL clear POINTER, WDATA, BYTE_NUM and all counters to 0, and set SLAVE_ADDRESS=SLAVE_ADDR.
REQ-018 Reset mid-operation SHALL abandon the sequence with no retry. GO=1 re-parks the writer after it ends its current transfer.

Configuration
REQ-019 With macro I2C_CFG_RETRY_EN defined, a NACK in CHECK SHALL relaunch the same entry up to 3 times, then go to FAULT. The retry count SHALL reset at each LOAD. Without the macro, a NACK SHALL go directly to FAULT.

Structure
REQ-020 A package i2c_cfg_pkg SHALL hold the entry TYPE encodings, the entry width (37), the state encoding and the retry limit (3).
REQ-021 The table SHALL be a sub-module i2c_config_rom (registered output, address INDEX).

Verification
REQ-022 A bench SHALL cover at least these scenarios:
- Table {WRITE 4B ptr 0x0001 dat 0x1234, END}, writer model ACKs -> exactly one GO low pulse; POINTER=0x0001 and WDATA=0x1234 stable throughout; DONE=1 and ERROR=0 afterwards.
- Table {WRITE, DELAY dat=2, WRITE, END} with DELAY_UNIT=10 -> at least 20 cycles between END_OK rising and the second GO low.
- Writer model NACKs the last byte, macro off -> ERROR=1 and INDEX=0; macro on -> 4 GO low pulses, then ERROR=1.
- END_OK held at 1 after launch -> FAULT 4 cycles later, ERROR=1.
- RESET_N low during WAIT_DONE -> GO=1, BUSY=0 immediately; a later START reruns the table from INDEX=0.
